// File: rtl/fp4_unpacker.sv
// Streaming fp4 (E2M1) word unpacker: one decoded MAC operand per cycle.
// Build option FP4_UNPACK_NORM_SUBNORM_EN normalizes subnormal 0.5 to I=1.
module fp4_unpacker #(
  parameter int LANES = 8,
  parameter int CW    = $clog2(LANES+1)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_clear,
  input  logic               i_word_valid,
  output logic               o_word_ready,
  input  logic [4*LANES-1:0] i_word,
  input  logic [CW-1:0]      i_lanes_used,
  input  logic               i_word_last,
  output logic               o_valid,
  input  logic               i_ready,
  output logic               o_sign,
  output logic [2:0]         o_exp_u,
  output logic [4:0]         o_sig_grs,
  output logic [CW-1:0]      o_lane,
  output logic               o_last
);

  localparam int            W    = 4*LANES;
  localparam logic [CW-1:0] LMAX = CW'(LANES);

  typedef enum logic {
    S_EMPTY,
    S_SERVE
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [W-1:0]  r_buf;
  logic [CW-1:0] r_lane;
  logic [CW-1:0] r_used;
  logic          r_last;

  logic          w_full;
  logic          w_lane_end;
  logic          w_consume;
  logic          w_ready;
  logic          w_accept;
  logic [CW-1:0] w_used_in;
  logic [W-1:0]  w_shifted;
  logic [3:0]    w_nib;

  assign w_full     = (r_state == S_SERVE);
  assign w_lane_end = (r_lane == r_used - CW'(1));
  assign w_consume  = w_full & i_ready;

  // Ready on the final element's consume cycle gives back-to-back words.
  assign w_ready = ~i_rst & ~i_clear &
                   (~w_full | (w_consume & w_lane_end));
  assign w_accept = i_word_valid & w_ready;

  assign w_used_in =
    ((i_lanes_used == '0) || (i_lanes_used > LMAX))
      ? LMAX : i_lanes_used;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_EMPTY: begin
        if (w_accept)
          w_state_nxt = S_SERVE;
      end
      S_SERVE: begin
        if (w_consume & w_lane_end & ~w_accept)
          w_state_nxt = S_EMPTY;
      end
    endcase
    if (i_clear)
      w_state_nxt = S_EMPTY;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      r_state <= S_EMPTY;
    else
      r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_buf  <= '0;
      r_lane <= '0;
      r_used <= LMAX;
      r_last <= 1'b0;
    end else if (i_clear) begin
      r_lane <= '0;
    end else if (w_accept) begin
      r_buf  <= i_word;
      r_used <= w_used_in;
      r_last <= i_word_last;
      r_lane <= '0;
    end else if (w_consume) begin
      if (w_lane_end)
        r_lane <= '0;
      else
        r_lane <= r_lane + CW'(1);
    end
  end

  assign w_shifted = r_buf >> {r_lane, 2'b00};
  assign w_nib     = w_shifted[3:0];

  // Zero (either sign) falls to the default and decodes as +0.
  always_comb begin
    o_sign    = 1'b0;
    o_exp_u   = 3'd0;
    o_sig_grs = 5'd0;
    if (w_full) begin
      unique case (1'b1)
        (w_nib[2:1] != 2'b00): begin
          o_sign    = w_nib[3];
          o_exp_u   = {1'b0, w_nib[2:1]} - 3'd1;
          o_sig_grs = {1'b1, w_nib[0], 3'b000};
        end
        (w_nib[2:0] == 3'b001): begin
          o_sign = w_nib[3];
`ifdef FP4_UNPACK_NORM_SUBNORM_EN
          o_exp_u   = 3'b111;
          o_sig_grs = 5'b10000;
`else
          o_exp_u   = 3'd0;
          o_sig_grs = 5'b01000;
`endif
        end
        default: begin
          o_sign    = 1'b0;
          o_exp_u   = 3'd0;
          o_sig_grs = 5'd0;
        end
      endcase
    end
  end

  assign o_word_ready = w_ready;
  assign o_valid      = w_full;
  assign o_lane       = r_lane;
  assign o_last       = w_full & r_last & w_lane_end;

endmodule

// File: tb/tb_fp4_unpacker.sv
// Bench for fp4_unpacker: value-level model queue plus directed vectors.
// Define FP4_UNPACK_NORM_SUBNORM_EN to check the normalizing build.
module tb_fp4_unpacker;

  localparam int LANES = 8;
  localparam int CW    = 4;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_clear;
  logic          i_word_valid;
  logic          o_word_ready;
  logic [31:0]   i_word;
  logic [CW-1:0] i_lanes_used;
  logic          i_word_last;
  logic          o_valid;
  logic          i_ready;
  logic          o_sign;
  logic [2:0]    o_exp_u;
  logic [4:0]    o_sig_grs;
  logic [CW-1:0] o_lane;
  logic          o_last;

  int nerr = 0;
  int nchk = 0;

  fp4_unpacker #(.LANES(LANES), .CW(CW)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_clear      (i_clear),
    .i_word_valid (i_word_valid),
    .o_word_ready (o_word_ready),
    .i_word       (i_word),
    .i_lanes_used (i_lanes_used),
    .i_word_last  (i_word_last),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_sign       (o_sign),
    .o_exp_u      (o_exp_u),
    .o_sig_grs    (o_sig_grs),
    .o_lane       (o_lane),
    .o_last       (o_last)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic       s;
    logic [2:0] e;
    logic [4:0] g;
    logic [3:0] lane;
    logic       last;
  } elem_t;

  elem_t q[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Decode from the numeric value in units of 0.5.
  function automatic elem_t model_elem(input logic [3:0] nib,
                                       input int lane,
                                       input bit last);
    elem_t r;
    int    e, m, h, k;
    e = int'(nib[2:1]);
    m = int'(nib[0]);
    h = (e == 0) ? m : ((2 + m) << (e - 1));
    r = '0;
    r.lane = 4'(lane);
    r.last = last;
    if (h == 1) begin
      r.s = nib[3];
`ifdef FP4_UNPACK_NORM_SUBNORM_EN
      r.e = 3'b111;
      r.g = 5'b10000;
`else
      r.e = 3'd0;
      r.g = 5'b01000;
`endif
    end else if (h > 1) begin
      k = 0;
      while ((h >> (k + 1)) != 0) k++;
      r.s = nib[3];
      r.e = 3'(k - 1);
      r.g = {1'b1, 1'((h >> (k - 1)) & 1), 3'b000};
    end
    return r;
  endfunction

  function automatic bit m_ready_f();
    return !i_rst && !i_clear &&
           (q.size() == 0 || (q.size() == 1 && i_ready));
  endfunction

  always @(posedge i_clk or posedge i_rst) begin
    bit acc;
    int n;
    if (i_rst || i_clear) begin
      q.delete();
    end else begin
      acc = i_word_valid && m_ready_f();
      if (q.size() != 0 && i_ready)
        void'(q.pop_front());
      if (acc) begin
        n = int'(i_lanes_used);
        if (n == 0 || n > LANES) n = LANES;
        for (int l = 0; l < n; l++)
          q.push_back(model_elem(i_word[4*l +: 4], l,
                                 i_word_last && (l == n - 1)));
      end
    end
  end

  always @(negedge i_clk) begin
    chk("valid", 32'(o_valid), 32'(q.size() != 0));
    chk("word_ready", 32'(o_word_ready), 32'(m_ready_f()));
    if (q.size() != 0) begin
      chk("sign", 32'(o_sign), 32'(q[0].s));
      chk("exp_u", 32'(o_exp_u), 32'(q[0].e));
      chk("sig_grs", 32'(o_sig_grs), 32'(q[0].g));
      chk("lane", 32'(o_lane), 32'(q[0].lane));
      chk("last", 32'(o_last), 32'(q[0].last));
    end
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send(input logic [31:0] w, input logic [3:0] lu,
                      input logic lst);
    i_word       = w;
    i_lanes_used = lu;
    i_word_last  = lst;
    i_word_valid = 1'b1;
    step();
    i_word_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && o_valid; k++) step();
    chk("drain", 32'(o_valid), 32'd0);
  endtask

  logic [11:0] held;

  initial begin
    i_rst = 1'b1;
    i_clear = 1'b0;
    i_word_valid = 1'b0;
    i_word = '0;
    i_lanes_used = '0;
    i_word_last = 1'b0;
    i_ready = 1'b1;
    repeat (3) step();
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_sig", 32'(o_sig_grs), 32'd0);
    i_rst = 1'b0;
    #1;
    chk("rst_wready", 32'(o_word_ready), 32'd1);

    // 1: 1.5 then -6.0
    send(32'h0000_00F3, 4'd2, 1'b1);
    chk("t1_s0", 32'(o_sign), 32'd0);
    chk("t1_e0", 32'(o_exp_u), 32'd0);
    chk("t1_g0", 32'(o_sig_grs), 32'b11000);
    chk("t1_l0", 32'(o_last), 32'd0);
    step();
    chk("t1_s1", 32'(o_sign), 32'd1);
    chk("t1_e1", 32'(o_exp_u), 32'd2);
    chk("t1_g1", 32'(o_sig_grs), 32'b11000);
    chk("t1_ln1", 32'(o_lane), 32'd1);
    chk("t1_l1", 32'(o_last), 32'd1);
    step();
    chk("t1_done", 32'(o_valid), 32'd0);

    // 2: subnormal and -0
    send(32'h0000_0081, 4'd2, 1'b0);
`ifdef FP4_UNPACK_NORM_SUBNORM_EN
    chk("t2_e0", 32'(o_exp_u), 32'd7);
    chk("t2_g0", 32'(o_sig_grs), 32'b10000);
`else
    chk("t2_e0", 32'(o_exp_u), 32'd0);
    chk("t2_g0", 32'(o_sig_grs), 32'b01000);
`endif
    step();
    chk("t2_s1", 32'(o_sign), 32'd0);
    chk("t2_g1", 32'(o_sig_grs), 32'd0);
    step();

    // 3: backpressure on lane 3 (nibble 0xD = -3.0)
    send(32'h9ABC_D2E7, 4'd0, 1'b1);
    repeat (3) step();
    chk("t3_lane", 32'(o_lane), 32'd3);
    chk("t3_sign", 32'(o_sign), 32'd1);
    chk("t3_exp", 32'(o_exp_u), 32'd1);
    chk("t3_sig", 32'(o_sig_grs), 32'b11000);
    held = {o_sign, o_exp_u, o_sig_grs, o_lane[2:0]};
    i_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t3_hold", 32'({o_sign, o_exp_u, o_sig_grs, o_lane[2:0]}),
          32'(held));
      chk("t3_wready", 32'(o_word_ready), 32'd0);
    end
    i_ready = 1'b1;
    step();
    chk("t3_next", 32'(o_lane), 32'd4);
    drain();

    // 4: back-to-back full words
    i_word = 32'h7654_3210;
    i_lanes_used = 4'd8;
    i_word_last = 1'b0;
    i_word_valid = 1'b1;
    step();
    i_word = 32'hFEDC_BA98;
    i_word_last = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("t4_valid", 32'(o_valid), 32'd1);
      chk("t4_wready", 32'(o_word_ready), 32'(i % 8 == 7));
      chk("t4_last", 32'(o_last), 32'(i == 15));
      step();
      if (i == 7) i_word_valid = 1'b0;
    end
    chk("t4_done", 32'(o_valid), 32'd0);

    // 5: clear on lane 4 with a competing word
    send(32'h1357_9BDF, 4'd8, 1'b0);
    repeat (4) step();
    chk("t5_lane", 32'(o_lane), 32'd4);
    i_clear = 1'b1;
    i_word = 32'h0000_0A53;
    i_lanes_used = 4'd12;
    i_word_last = 1'b1;
    i_word_valid = 1'b1;
    #1;
    chk("t5_wr_clr", 32'(o_word_ready), 32'd0);
    step();
    i_clear = 1'b0;
    #1;
    chk("t5_valid", 32'(o_valid), 32'd0);
    chk("t5_wready", 32'(o_word_ready), 32'd1);
    step();
    i_word_valid = 1'b0;
    chk("t5_acc", 32'(o_valid), 32'd1);
    chk("t5_lane0", 32'(o_lane), 32'd0);
    chk("t5_sig", 32'(o_sig_grs), 32'b11000);
    drain();

    // 6: async reset mid-word
    send(32'h5555_5555, 4'd8, 1'b1);
    repeat (2) step();
    #2;
    i_rst = 1'b1;
    #1;
    chk("t6_valid", 32'(o_valid), 32'd0);
    step();
    i_rst = 1'b0;
    #1;
    chk("t6_lane", 32'(o_lane), 32'd0);
    chk("t6_wready", 32'(o_word_ready), 32'd1);
    chk("t6_valid2", 32'(o_valid), 32'd0);
    step();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
